// File: rtl/fht_pkg.sv
// fht_pkg: shared types and helpers for the FHT control/address sequencer.
//   fht_state_e       - sequencer FSM state encoding
//   FHT_LOG2_N_DEF    - default log2 of the transform length
//   FHT_PIPE_LAT_DEF  - default read-to-write butterfly latency
//   stage_len()       - cycles per stage, T = 2*M + PIPE_LAT
//   sector_shift()    - log2 of the sector length L for a given stage
package fht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fht_state_e;

  localparam int unsigned FHT_LOG2_N_DEF   = 10;
  localparam int unsigned FHT_PIPE_LAT_DEF = 6;

  function automatic int unsigned stage_len(input int unsigned a_bit,
                                            input int unsigned pipe_lat);
    return (32'd2 << a_bit) + pipe_lat;
  endfunction

  // Stage 0 and stage 1 both use full-bank sectors; after that L halves.
  function automatic int unsigned sector_shift(input int unsigned s,
                                               input int unsigned a_bit);
    if (s == 0) return a_bit;
    return a_bit - (s - 1);
  endfunction

endpackage

// File: rtl/fht_wr_delay.sv
// fht_wr_delay: fixed-depth shift register that carries the write address,
// partner write address and write-valid bit from the read side to the
// write side of the butterfly pipeline.
//   clk_sys - clock
//   rst_b   - asynchronous active-low reset
//   clr     - synchronous clear of every stage (wins over en)
//   en      - shift enable; low freezes the contents
//   d       - word entering the line
//   q       - word that entered DEPTH shifts ago
module fht_wr_delay #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 6
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] pipe_q;
  logic [DEPTH-1:0][W-1:0] pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (clr) begin
      pipe_d = '0;
    end else if (en) begin
      pipe_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_seq_ctrl.sv
// fht_seq_ctrl: control and address sequencer for a radix-2 FHT engine with
// four RAM banks. Walks all LOG2_N stages, generating direct and reflected
// read addresses, delayed write addresses with ping-pong write strobes,
// twiddle ROM addresses and mixer controls.
//
// Optional build macro: FHT_SEQ_STALL_EN adds input iSTALL, which freezes the
// counters, FSM and write delay line and masks the write strobes.
//
// Ports:
//   iCLK, iRESET (async, active-low)  clock and reset
//   iSTART / iABORT                   start request / synchronous abort
//   oRDY, oDONE, oSOURCE_CONT         idle, completion pulse, host owns RAM
//   oST_ZERO, oST_LAST                first / last stage running
//   o2ND_PART_SUBSEC, oSECTOR         sector position of the read address
//   oADDR_RD_0..3                     direct (0,2) and partner (1,3) reads
//   oADDR_WR, oADDR_WR_BIAS           delayed direct / partner writes
//   oADDR_COEF                        twiddle ROM address
//   oWE_A, oWE_B, oSOURCE_DATA        write strobes and read bank-set select
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | host owns RAM, waiting for iSTART
// RUN     | sequencing stages 0..LOG2_N-1
// DONE    | one-cycle completion pulse, then back to IDLE
module fht_seq_ctrl
  import fht_pkg::*;
#(
  parameter int unsigned LOG2_N   = FHT_LOG2_N_DEF,
  parameter int unsigned A_BIT    = LOG2_N - 2,
  parameter int unsigned PIPE_LAT = FHT_PIPE_LAT_DEF
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iABORT,
`ifdef FHT_SEQ_STALL_EN
  input  logic             iSTALL,
`endif
  output logic             oRDY,
  output logic             oDONE,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             o2ND_PART_SUBSEC,
  output logic [A_BIT-1:0] oSECTOR,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [A_BIT-1:0] oADDR_WR_BIAS,
  output logic [A_BIT-1:0] oADDR_COEF,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic             oSOURCE_DATA,
  output logic             oSOURCE_CONT
);

  localparam int unsigned T_LEN = stage_len(A_BIT, PIPE_LAT);
  localparam int unsigned CW    = $clog2(T_LEN);
  localparam int unsigned SW    = $clog2(LOG2_N);
  localparam int unsigned SHW   = $clog2(A_BIT + 1);
  localparam int unsigned DW    = 2 * A_BIT + 1;

  // Stage timer counts down from T-1; cycle index c = T-1 - cnt.
  // c < 2M is equivalent to cnt >= PIPE_LAT.
  localparam logic [CW-1:0] CNT_TOP  = CW'(T_LEN - 1);
  localparam logic [CW-1:0] CNT_WEND = CW'(PIPE_LAT);
  localparam logic [SW-1:0] S_LAST   = SW'(LOG2_N - 1);

  function automatic logic [A_BIT-1:0] ra_of(input logic [CW-1:0] cnt);
    logic [CW-1:0] c;
    c = CNT_TOP - cnt;
    if (cnt >= CNT_WEND) return A_BIT'(c >> 1);
    return {A_BIT{1'b1}};
  endfunction

  function automatic logic [A_BIT-1:0] mask_of(input logic [SW-1:0] s);
    logic [SHW-1:0] sh;
    sh = SHW'(sector_shift(32'(s), A_BIT));
    return ~({A_BIT{1'b1}} << sh);
  endfunction

  // o >= L/2 is simply the top bit of the offset field.
  function automatic logic sub2_of(input logic [A_BIT-1:0] ra,
                                   input logic [A_BIT-1:0] mask);
    return |(ra & (mask ^ (mask >> 1)));
  endfunction

  logic stall;
`ifdef FHT_SEQ_STALL_EN
  assign stall = iSTALL;
`else
  assign stall = 1'b0;
`endif

  fht_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s_q, s_d;
  logic          src_q, src_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;
  logic          cont_q, cont_d;
  logic          st_zero_q, st_zero_d;
  logic          st_last_q, st_last_d;
  logic          sub2_q, sub2_d;
  logic          stage_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    src_d     = src_q;
    stage_end = 1'b0;
    if (iABORT) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_TOP;
      s_d     = '0;
      src_d   = 1'b0;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (iSTART) begin
            state_d = ST_RUN;
            cnt_d   = CNT_TOP;
            s_d     = '0;
            src_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            stage_end = 1'b1;
            cnt_d     = CNT_TOP;
            if (s_q == S_LAST) begin
              state_d = ST_DONE;
              s_d     = '0;
              src_d   = 1'b0;
            end else begin
              s_d   = s_q + SW'(1);
              src_d = ~src_q;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next-state values so they line
  // up with the combinational addresses derived from the same counters.
  always_comb begin
    rdy_d     = (state_d != ST_RUN);
    done_d    = (state_d == ST_DONE);
    cont_d    = (state_d == ST_IDLE);
    st_zero_d = (state_d == ST_RUN) && (s_d == '0);
    st_last_d = (state_d == ST_RUN) && (s_d == S_LAST);
    sub2_d    = (state_d == ST_RUN) && sub2_of(ra_of(cnt_d), mask_of(s_d));
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_TOP;
      s_q       <= '0;
      src_q     <= 1'b0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      cont_q    <= 1'b1;
      st_zero_q <= 1'b0;
      st_last_q <= 1'b0;
      sub2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      src_q     <= src_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      cont_q    <= cont_d;
      st_zero_q <= st_zero_d;
      st_last_q <= st_last_d;
      sub2_q    <= sub2_d;
    end
  end

  logic [CW-1:0]    c_cur;
  logic [A_BIT-1:0] ra_cur;
  logic [A_BIT-1:0] mask_cur;
  logic [A_BIT-1:0] part_cur;
  logic [A_BIT-1:0] coef_cur;
  logic             wv_cur;

  always_comb begin
    c_cur    = CNT_TOP - cnt_q;
    ra_cur   = ra_of(cnt_q);
    mask_cur = mask_of(s_q);
    // Reflected partner: base + ((L - o) mod L), i.e. the low field negated.
    part_cur = (ra_cur & ~mask_cur) | ((A_BIT'(0) - ra_cur) & mask_cur);
    coef_cur = '0;
    if (s_q != '0) coef_cur = (ra_cur & mask_cur) << (s_q - SW'(1));
    wv_cur   = (state_q == ST_RUN) && (cnt_q >= CNT_WEND) && c_cur[0];
  end

  logic [DW-1:0] dly_q;
  logic          dly_clr;

  assign dly_clr = iABORT || (state_q != ST_RUN) || stage_end;

  fht_wr_delay #(
    .W     (DW),
    .DEPTH (PIPE_LAT)
  ) u_wr_delay (
    .clk_sys (iCLK),
    .rst_b   (iRESET),
    .clr     (dly_clr),
    .en      (!stall),
    .d       ({wv_cur, ra_cur, part_cur}),
    .q       (dly_q)
  );

  assign oRDY             = rdy_q;
  assign oDONE            = done_q;
  assign oSOURCE_CONT     = cont_q;
  assign oST_ZERO         = st_zero_q;
  assign oST_LAST         = st_last_q;
  assign o2ND_PART_SUBSEC = sub2_q;
  assign oSOURCE_DATA     = src_q;
  assign oSECTOR          = ra_cur >> SHW'(sector_shift(32'(s_q), A_BIT));
  assign oADDR_RD_0       = ra_cur;
  assign oADDR_RD_2       = ra_cur;
  assign oADDR_RD_1       = part_cur;
  assign oADDR_RD_3       = part_cur;
  assign oADDR_COEF       = coef_cur;
  assign oADDR_WR         = dly_q[2*A_BIT-1:A_BIT];
  assign oADDR_WR_BIAS    = dly_q[A_BIT-1:0];
  // A held delay line would re-issue its write every stalled cycle, so the
  // strobes are masked directly while stalled.
  assign oWE_A            = dly_q[DW-1] & src_q & ~stall;
  assign oWE_B            = dly_q[DW-1] & ~src_q & ~stall;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
module tb_fht_seq_ctrl;

  localparam int LN = 4;
  localparam int AB = 2;
  localparam int PL = 2;
  localparam int M  = 4;
  localparam int T  = 10;
  localparam int RUN_LEN = LN * T;

  logic          iCLK = 1'b0;
  logic          iRESET, iSTART, iABORT;
`ifdef FHT_SEQ_STALL_EN
  logic          iSTALL = 1'b0;
`endif
  logic          oRDY, oDONE, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
  logic [AB-1:0] oSECTOR, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [AB-1:0] oADDR_WR, oADDR_WR_BIAS, oADDR_COEF;
  logic          oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int t;
    bit a;
    int addr;
    int bias;
  } wr_t;
  wr_t sb[$];

  always #5 iCLK = ~iCLK;

  fht_seq_ctrl #(.LOG2_N(LN), .PIPE_LAT(PL)) dut (
    .iCLK             (iCLK),
    .iRESET           (iRESET),
    .iSTART           (iSTART),
    .iABORT           (iABORT),
`ifdef FHT_SEQ_STALL_EN
    .iSTALL           (iSTALL),
`endif
    .oRDY             (oRDY),
    .oDONE            (oDONE),
    .oST_ZERO         (oST_ZERO),
    .oST_LAST         (oST_LAST),
    .o2ND_PART_SUBSEC (o2ND_PART_SUBSEC),
    .oSECTOR          (oSECTOR),
    .oADDR_RD_0       (oADDR_RD_0),
    .oADDR_RD_1       (oADDR_RD_1),
    .oADDR_RD_2       (oADDR_RD_2),
    .oADDR_RD_3       (oADDR_RD_3),
    .oADDR_WR         (oADDR_WR),
    .oADDR_WR_BIAS    (oADDR_WR_BIAS),
    .oADDR_COEF       (oADDR_COEF),
    .oWE_A            (oWE_A),
    .oWE_B            (oWE_B),
    .oSOURCE_DATA     (oSOURCE_DATA),
    .oSOURCE_CONT     (oSOURCE_CONT)
  );

  // Every output that must be 0 at reset / idle.
  logic [22:0] others;
  assign others = {oDONE, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oWE_A, oWE_B,
                   oSOURCE_DATA, oSECTOR, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2,
                   oADDR_RD_3, oADDR_WR, oADDR_WR_BIAS, oADDR_COEF};

  // Reference model of cycle j (0 = first cycle after the start edge).
  function automatic void model(input int j, output int s, output int ra,
                                output int part, output int sec,
                                output int coef, output int sub2,
                                output int wv);
    int c, len, o;
    s    = j / T;
    c    = j % T;
    ra   = (c < 2 * M) ? c / 2 : M - 1;
    wv   = ((c < 2 * M) && (c % 2 == 1)) ? 1 : 0;
    len  = (s == 0) ? M : (M >> (s - 1));
    o    = ra % len;
    part = (ra - o + ((len - o) % len)) % M;
    sec  = ra / len;
    sub2 = (len > 1 && o >= len / 2) ? 1 : 0;
    coef = (s == 0) ? 0 : ((o << (s - 1)) % M);
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic start_run();
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic test_reset();
    iRESET = 1'b0;
    iSTART = 1'b0;
    iABORT = 1'b0;
    #12;
    checks++;
    if (oRDY !== 1'b1 || oSOURCE_CONT !== 1'b1 || others !== '0) begin
      errors++;
      $display("FAIL reset_values rdy=%b cont=%b others=%h, required 1 1 0", oRDY, oSOURCE_CONT, others);
    end
    @(negedge iCLK);
    iRESET = 1'b1;
    repeat (3) tick();
    checks++;
    if (oRDY !== 1'b1 || oSOURCE_CONT !== 1'b1 || others !== '0) begin
      errors++;
      $display("FAIL idle_values rdy=%b cont=%b others=%h, required 1 1 0", oRDY, oSOURCE_CONT, others);
    end
  endtask

  task automatic test_full_run();
    int s, ra, part, sec, coef, sub2, wv;
    int n_wr[LN];
    logic [18:0] act, exp_v;
    wr_t e;
    for (int i = 0; i < LN; i++) n_wr[i] = 0;
    sb.delete();
    start_run();
    for (int j = 0; j <= RUN_LEN + 1; j++) begin
      if (j < RUN_LEN) begin
        model(j, s, ra, part, sec, coef, sub2, wv);
        if (wv != 0) sb.push_back('{j + PL, (s % 2 == 1), ra, part});
        act   = {oADDR_RD_0, oADDR_RD_2, oADDR_RD_1, oADDR_RD_3, oSECTOR,
                 oADDR_COEF, o2ND_PART_SUBSEC, oST_ZERO, oST_LAST, oSOURCE_DATA,
                 oRDY, oSOURCE_CONT, oDONE};
        exp_v = {2'(ra), 2'(ra), 2'(part), 2'(part), 2'(sec), 2'(coef),
                 (sub2 != 0), (s == 0), (s == LN - 1), (s % 2 == 1),
                 1'b0, 1'b0, 1'b0};
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL run_outputs j=%0d got %h required %h", j, act, exp_v);
        end
      end else begin
        checks++;
        if ({oDONE, oRDY, oSOURCE_CONT} !== ((j == RUN_LEN) ? 3'b110 : 3'b011)) begin
          errors++;
          $display("FAIL done_pulse j=%0d done/rdy/cont got %b", j, {oDONE, oRDY, oSOURCE_CONT});
        end
      end
      if (oWE_A === 1'b1 || oWE_B === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write j=%0d we_a=%b we_b=%b", j, oWE_A, oWE_B);
        end else begin
          e = sb.pop_front();
          if (j < RUN_LEN) n_wr[j / T]++;
          if (j !== e.t || oWE_A !== e.a || oWE_B !== !e.a ||
              32'(oADDR_WR) !== e.addr || 32'(oADDR_WR_BIAS) !== e.bias) begin
            errors++;
            $display("FAIL write_event j=%0d a=%b b=%b addr=%0d bias=%0d, required j=%0d a=%0d addr=%0d bias=%0d",
                     j, oWE_A, oWE_B, oADDR_WR, oADDR_WR_BIAS, e.t, e.a, e.addr, e.bias);
          end
        end
      end
      // A start request mid-run must be ignored.
      iSTART = (j == 12) ? 1'b1 : 1'b0;
      tick();
    end
    iSTART = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got %0d outstanding, required 0", sb.size());
    end
    for (int i = 0; i < LN; i++) begin
      checks++;
      if (n_wr[i] != M) begin
        errors++;
        $display("FAIL writes_per_stage stage=%0d got %0d required %0d", i, n_wr[i], M);
      end
    end
  endtask

  task automatic test_stage_addr();
    start_run();
    for (int j = 0; j <= RUN_LEN + 1; j++) begin
      if (j == 11) begin
        checks++;
        if (oADDR_RD_0 !== 2'd0 || oADDR_RD_1 !== 2'd0) begin
          errors++;
          $display("FAIL stage1_ra0 ra=%0d partner=%0d, required 0 0", oADDR_RD_0, oADDR_RD_1);
        end
      end
      if (j == 12) begin
        checks++;
        if (oADDR_RD_0 !== 2'd1 || oADDR_RD_1 !== 2'd3 || oADDR_COEF !== 2'd1) begin
          errors++;
          $display("FAIL stage1_ra1 ra=%0d partner=%0d coef=%0d, required 1 3 1", oADDR_RD_0, oADDR_RD_1, oADDR_COEF);
        end
      end
      if (j == 26) begin
        checks++;
        if (oADDR_RD_0 !== 2'd3 || oADDR_RD_3 !== 2'd3 || oSECTOR !== 2'd1 ||
            oADDR_COEF !== 2'd2 || o2ND_PART_SUBSEC !== 1'b1) begin
          errors++;
          $display("FAIL stage2_ra3 ra=%0d partner=%0d sec=%0d coef=%0d sub2=%b, required 3 3 1 2 1",
                   oADDR_RD_0, oADDR_RD_3, oSECTOR, oADDR_COEF, o2ND_PART_SUBSEC);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int s, ra, part, sec, coef, sub2, wv;
    wr_t e;
    sb.delete();
    start_run();
    for (int j = 0; j <= 15; j++) begin
      model(j, s, ra, part, sec, coef, sub2, wv);
      if (wv != 0) sb.push_back('{j + PL, (s % 2 == 1), ra, part});
      if (oWE_A === 1'b1 || oWE_B === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL abort_unexpected_write j=%0d", j);
        end else begin
          e = sb.pop_front();
          if (j !== e.t || oWE_A !== e.a || 32'(oADDR_WR) !== e.addr) begin
            errors++;
            $display("FAIL abort_write j=%0d a=%b addr=%0d, required j=%0d a=%0d addr=%0d",
                     j, oWE_A, oADDR_WR, e.t, e.a, e.addr);
          end
        end
      end
      if (j < 15) tick();
    end
    iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    while (sb.size() > 0 && sb[$].t > 15) void'(sb.pop_back());
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL abort_pre_writes got %0d outstanding, required 0", sb.size());
    end
    checks++;
    if (oRDY !== 1'b1 || oSOURCE_CONT !== 1'b1 || others !== '0) begin
      errors++;
      $display("FAIL abort_idle rdy=%b cont=%b others=%h, required 1 1 0", oRDY, oSOURCE_CONT, others);
    end
    for (int j = 0; j < 40; j++) begin
      checks++;
      if (oDONE !== 1'b0 || oWE_A !== 1'b0 || oWE_B !== 1'b0 || oRDY !== 1'b1) begin
        errors++;
        $display("FAIL abort_quiet k=%0d done=%b we=%b%b rdy=%b", j, oDONE, oWE_A, oWE_B, oRDY);
      end
      tick();
    end
  endtask

  task automatic test_abort_with_start();
    iSTART = 1'b1;
    iABORT = 1'b1;
    tick();
    iSTART = 1'b0;
    iABORT = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (oRDY !== 1'b1 || oST_ZERO !== 1'b0 || oSOURCE_CONT !== 1'b1) begin
        errors++;
        $display("FAIL abort_start_idle k=%0d rdy=%b zero=%b cont=%b, required 1 0 1", j, oRDY, oST_ZERO, oSOURCE_CONT);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    start_run();
    repeat (13) tick();
    checks++;
    if (oRDY !== 1'b0) begin
      errors++;
      $display("FAIL midrun_running rdy=%b, required 0", oRDY);
    end
    #2;
    iRESET = 1'b0;
    #1;
    checks++;
    if (oRDY !== 1'b1 || oSOURCE_CONT !== 1'b1 || others !== '0) begin
      errors++;
      $display("FAIL midrun_reset rdy=%b cont=%b others=%h, required 1 1 0", oRDY, oSOURCE_CONT, others);
    end
    @(negedge iCLK);
    iRESET = 1'b1;
    tick();
  endtask

`ifdef FHT_SEQ_STALL_EN
  task automatic test_stall();
    start_run();
    for (int j = 0; j <= RUN_LEN + 6; j++) begin
      checks++;
      if (oDONE !== (j == RUN_LEN + 5)) begin
        errors++;
        $display("FAIL stall_done j=%0d got %b", j, oDONE);
      end
      iSTALL = (j >= 10 && j < 15) ? 1'b1 : 1'b0;
      #1;
      if (iSTALL) begin
        checks++;
        if (oWE_A !== 1'b0 || oWE_B !== 1'b0) begin
          errors++;
          $display("FAIL stall_we j=%0d we=%b%b, required 00", j, oWE_A, oWE_B);
        end
      end
      tick();
    end
    iSTALL = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_stage_addr();
    test_abort();
    test_abort_with_start();
    test_reset_mid_run();
`ifdef FHT_SEQ_STALL_EN
    test_stall();
`endif
    test_full_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
